// File: rtl/priority_encoder_hs.sv
// priority_encoder_hs: registered 2^W-to-W priority encoder with sticky request
// capture and a valid/ack handshake. The issued code is held until acknowledged.
//
// Build option: define PRIORITY_ENC_ROUND_ROBIN_EN for round-robin selection
// (pointer = last issued index + 1). Default build is fixed priority, index 0 highest.
module priority_encoder_hs #(
  parameter int unsigned W = 2,
  localparam int unsigned N = 1 << W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] y,
  output logic         valid,
  output logic [N-1:0] pending,
  output logic         multi
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   y_q, y_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           multi_q, multi_d;
  logic [N-1:0]   clr;
  logic [W-1:0]   base;
  logic [W-1:0]   sel;
  logic [W-1:0]   idx;
  logic           found;

`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
  logic [W-1:0]   ptr_q, ptr_d;
  assign base = ptr_q;
`else
  assign base = '0;
`endif

  // Search the registered pending vector starting at base, wrapping N-1 -> 0.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = base + W'(k);
      if (!found && pending_q[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // Capture, handshake FSM and status flag next-state.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    clr     = '0;
`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (en && found) begin
          y_d     = sel;
          state_d = StHold;
        end
      end
      StHold: begin
        if (ack) begin
          clr[y_q] = 1'b1;
          state_d  = StIdle;
`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
          ptr_d    = y_q + W'(1);
`endif
        end
      end
      default: state_d = StIdle;
    endcase
    // A set in the same cycle as the clear wins.
    pending_d = (pending_q & ~clr) | req;
    // More than one bit set: clearing the lowest set bit leaves something.
    multi_d   = |(pending_q & (pending_q - N'(1)));
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      y_q       <= '0;
      pending_q <= '0;
      multi_q   <= 1'b0;
`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      pending_q <= pending_d;
      multi_q   <= multi_d;
`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign y       = y_q;
  assign valid   = (state_q == StHold);
  assign pending = pending_q;
  assign multi   = multi_q;

endmodule

// File: doc/priority_encoder_hs.md
# priority_encoder_hs

Registered 2^W-to-W priority encoder with request capture and valid/ack handshake; the inverse of the team's active-high enabled 2-to-4 decoder. Level or pulse requests on `req` are held in a sticky pending register, and the highest-priority pending index is presented as a binary code on `y` with `valid`. The code is held until the consumer returns `ack`. The block sits in front of the decoder so that the decoder's output reconstructs the selected one-hot line.

## Interface
- `W`, default 2: code width. Number of request lines N = 2^W.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous reset, active high.
- `en` input 1: issue enable. Low blocks new codes from issuing; capture continues.
- `req` input N: request lines; bit k requests code k.
- `ack` input 1: consumer accepts the current code.
- `y` output W: encoded index. Stable while `valid`=1.
- `valid` output 1: `y` holds a code awaiting `ack`.
- `pending` output N: sticky pending register, for debug and status.
- `multi` output 1: registered flag, high while more than one `pending` bit is set.

## Operation
- Capture: `pending_next = (pending & ~clr) | req`.
  - `clr` is one-hot of `y` when `valid & ack`, otherwise 0.
  - If `req[y]` is high in the same cycle as `ack`, the set wins and the bit stays pending.
- FSM states:
  - IDLE (`valid`=0):
    - If `en`=1 and `pending`≠0: load `y` with the selected index, set `valid`=1, go to HOLD.
    - Otherwise remain in IDLE; `y` keeps its last value.
  - HOLD (`valid`=1):
    - `y` is frozen. `en` is ignored.
    - On `ack`=1: clear `pending[y]`, set `valid`=0, go to IDLE.
    - Otherwise remain in HOLD.
- Selection (default): fixed priority, lowest index wins (`req[0]` highest priority).
- Selection uses the registered `pending` only. A request appearing this cycle is not eligible this cycle.
- `ack` while in IDLE is ignored, with no effect on `pending`.
- Reset values: `y`=0, `valid`=0, `pending`=0, `multi`=0, FSM=IDLE. Rotation pointer=0 when configured.
- Reset mid-HOLD: `valid` drops at that edge, pending requests are lost, and `ack` in the same cycle is ignored.

## Timing
- Latency, `req[k]` pulse at edge t to `valid`=1 with `y`=k:
  - `pending[k]` is set at edge t.
  - `valid` and `y` are registered at edge t+1, provided the FSM is in IDLE and `en`=1.
- `ack` sampled high at edge t: `valid`=0 after t, and `pending[y]` is cleared at t.
  - The next code may issue at edge t+1.
  - Maximum throughput is one code per 2 cycles.
- `multi` reflects `pending` with one cycle of delay.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `PRIORITY_ENC_ROUND_ROBIN_EN` defined:
  - Selection is round-robin. A W-bit pointer holds (last issued index + 1) mod N, updated on each `ack`.
  - The search starts at the pointer and wraps from N-1 to 0.
  - The pointer resets to 0.
- Not defined: fixed lowest-index priority, with no pointer state.
- Interface and timing are identical in both builds.

## Test plan
- Single request, fixed priority. `req`=4'b0100 for one cycle, `en`=1 → `valid`=1 and `y`=2 two edges later. Hold `ack`=0 for 5 cycles → `y` stays 2. `ack`=1 → `valid`=0 and `pending`=0.
- Priority order. `req`=4'b1010 for one cycle → `y`=1 and `multi`=1. After `ack`: `y`=3 issues, then `ack` → `pending`=0 and `multi`=0.
- Gating. `en`=0 with `req`=4'b0001 → `pending`=4'b0001 and `valid` stays 0 for 10 cycles. Raise `en` → `valid`=1 and `y`=0 on the next edge.
- Same-cycle set/clear. In HOLD with `y`=0, drive `ack`=1 and `req[0]`=1 together → `pending[0]` stays 1, and `y`=0 reissues 1 cycle after `valid` falls.
- Reset mid-operation. In HOLD with `pending`=4'b1111, assert `rst` for one edge → `valid`=0, `y`=0, `pending`=0, `multi`=0. `ack` during that edge has no effect.
- Round-robin build. Hold `req`=4'b1111 with `ack`=1 whenever `valid` → issued sequence is `y`=0,1,2,3,0. The fixed-priority build gives 0,0,0…
